vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. It drives `pixel_x`, `pixel_y` and `video_on` into the downstream scene renderers, which register colour one cycle later. It also drives the `hsync`/`vsync` pins, delayed so they stay aligned with that registered colour. It is the stage directly upstream of every scene block.

---
 rtl/vga_timing_gen_pkg.sv | 31 +++
 rtl/vga_timing_gen_if.sv | 20 ++
 rtl/vga_timing_gen_sync_delay_line.sv | 34 +++
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA 640x480@60 timing constants, sync polarity and run-state type.
// Scene blocks import H_VIDEO/V_VIDEO from here instead of restating them.
package vga_timing_pkg;

  localparam int H_VIDEO = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int V_VIDEO = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;

  localparam int H_TOTAL = H_VIDEO + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIDEO + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_ACTIVE = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_state_t;

  // 11-bit compare so a window ending exactly at 1024 still works.
  function automatic logic in_window(input logic [9:0] pos, input int lo, input int len);
    logic [10:0] p;
    p = {1'b0, pos};
    return (p >= 11'(lo)) && (p < 11'(lo + len));
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the scene renderers.
interface vga_timing_gen_if;

  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       line_start;
  logic       frame_start;
  logic       hsync;
  logic       vsync;

  modport master (
    output pixel_x, pixel_y, video_on, line_start, frame_start, hsync, vsync
  );

  modport slave (
    input pixel_x, pixel_y, video_on, line_start, frame_start, hsync, vsync
  );

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Depth-N shift register for a sync pin; DEPTH 0 is a plain wire.
// Every stage resets to RESET_VAL so the pin idles inactive.
module sync_delay_line #(
  parameter int   DEPTH     = 1,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_0,
  input  logic rst,
  input  logic din,
  output logic dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_shift
      logic [DEPTH-1:0] shift_reg;

      always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
          shift_reg <= {DEPTH{RESET_VAL}};
        end else begin
          shift_reg[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            shift_reg[i] <= shift_reg[i-1];
          end
        end
      end

      assign dout = shift_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counter with registered decodes; hsync/vsync are delayed to line
// up with the scene's registered colour.
module vga_timing_gen
  import vga_timing_pkg::run_state_t, vga_timing_pkg::IDLE, vga_timing_pkg::RUN,
         vga_timing_pkg::in_window;
#(
  parameter int   H_VIDEO     = vga_timing_pkg::H_VIDEO,
  parameter int   H_FP        = vga_timing_pkg::H_FP,
  parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int   H_BP        = vga_timing_pkg::H_BP,
  parameter int   V_VIDEO     = vga_timing_pkg::V_VIDEO,
  parameter int   V_FP        = vga_timing_pkg::V_FP,
  parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int   V_BP        = vga_timing_pkg::V_BP,
  parameter logic SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE,
  parameter int   SYNC_DELAY  = 1
) (
  input  logic             clk_0,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam logic [9:0] H_LAST = 10'(H_VIDEO + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_VIDEO + V_FP + V_SYNC + V_BP - 1);

  run_state_t state_reg, state_next;
  logic [9:0] x_reg, x_next;
  logic [9:0] y_reg, y_next;
  logic       video_on_reg, video_on_next;
  logic       line_start_reg, line_start_next;
  logic       frame_start_reg, frame_start_next;
  logic       hsync_raw_reg, hsync_raw_next;
  logic       vsync_raw_reg, vsync_raw_next;
  logic       hsync_dly, vsync_dly;

  // Decodes use the next counter values so they land with pixel_x/pixel_y.
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    case (state_reg)
      IDLE: begin
        state_next = RUN;
        x_next     = '0;
        y_next     = '0;
      end
      RUN: begin
        if (x_reg == H_LAST) begin
          x_next = '0;
          y_next = (y_reg == V_LAST) ? '0 : y_reg + 10'd1;
        end else begin
          x_next = x_reg + 10'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    video_on_next    = (state_next == RUN)
                       && ({1'b0, x_next} < 11'(H_VIDEO))
                       && ({1'b0, y_next} < 11'(V_VIDEO));
    line_start_next  = (state_next == RUN) && (x_next == '0);
    frame_start_next = line_start_next && (y_next == '0);
    hsync_raw_next   = in_window(x_next, H_VIDEO + H_FP, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_raw_next   = in_window(y_next, V_VIDEO + V_FP, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      x_reg           <= '0;
      y_reg           <= '0;
      video_on_reg    <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      hsync_raw_reg   <= ~SYNC_ACTIVE;
      vsync_raw_reg   <= ~SYNC_ACTIVE;
    end else begin
      state_reg       <= state_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      video_on_reg    <= video_on_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
      hsync_raw_reg   <= hsync_raw_next;
      vsync_raw_reg   <= vsync_raw_next;
    end
  end

  sync_delay_line #(.DEPTH(SYNC_DELAY), .RESET_VAL(~SYNC_ACTIVE)) u_hsync_dly (
    .clk_0 (clk_0),
    .rst   (rst),
    .din   (hsync_raw_reg),
    .dout  (hsync_dly)
  );

  sync_delay_line #(.DEPTH(SYNC_DELAY), .RESET_VAL(~SYNC_ACTIVE)) u_vsync_dly (
    .clk_0 (clk_0),
    .rst   (rst),
    .din   (vsync_raw_reg),
    .dout  (vsync_dly)
  );

  assign vga.pixel_x     = x_reg;
  assign vga.pixel_y     = y_reg;
  assign vga.video_on    = video_on_reg;
  assign vga.line_start  = line_start_reg;
  assign vga.frame_start = frame_start_reg;
  assign vga.hsync       = hsync_dly;
  assign vga.vsync       = vsync_dly;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: one default-timing DUT plus two shrunken-timing DUTs
// (sync delay 0 and 3) so frame wraps and vsync are reached in few cycles.
module tb_vga_timing_gen;

  logic clk_0 = 1'b0;
  logic rst   = 1'b0;

  always #5 clk_0 = ~clk_0;

  vga_timing_gen_if if_d ();
  vga_timing_gen_if if_s0 ();
  vga_timing_gen_if if_s3 ();

  vga_timing_gen u_dut_d (
    .clk_0 (clk_0),
    .rst   (rst),
    .vga   (if_d)
  );

  vga_timing_gen #(
    .H_VIDEO(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_VIDEO(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_DELAY(0)
  ) u_dut_s0 (
    .clk_0 (clk_0),
    .rst   (rst),
    .vga   (if_s0)
  );

  vga_timing_gen #(
    .H_VIDEO(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_VIDEO(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_DELAY(3)
  ) u_dut_s3 (
    .clk_0 (clk_0),
    .rst   (rst),
    .vga   (if_s3)
  );

  typedef struct packed {
    logic [26:0] d;
    logic [26:0] s0;
    logic [26:0] s3;
    int          n;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   running = 1'b0;
  int   n = 0;
  event sample_ev;

  // Reference: position is simply the cycle count since release folded into
  // the raster; syncs are the same rule applied SYNC_DELAY cycles earlier.
  function automatic logic [26:0] model(input int hv, hf, hs, hb, vv, vf, vs, vb, d,
                                        input bit run, input int cyc);
    int ht, vt, x, y, xm, ym, m;
    logic von, ls, fs, hsy, vsy;
    if (!run) return {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    x   = cyc % ht;
    y   = (cyc / ht) % vt;
    von = (x < hv) && (y < vv);
    ls  = (x == 0);
    fs  = (x == 0) && (y == 0);
    m   = cyc - d;
    hsy = 1'b1;
    vsy = 1'b1;
    if (m >= 0) begin
      xm  = m % ht;
      ym  = (m / ht) % vt;
      hsy = !((xm >= hv + hf) && (xm < hv + hf + hs));
      vsy = !((ym >= vv + vf) && (ym < vv + vf + vs));
    end
    return {10'(x), 10'(y), von, ls, fs, hsy, vsy};
  endfunction

  task automatic push_expect();
    exp_t e;
    e.d  = model(640, 16, 96, 48, 480, 10, 2, 33, 1, running, n);
    e.s0 = model(16, 4, 6, 6, 12, 2, 2, 3, 0, running, n);
    e.s3 = model(16, 4, 6, 6, 12, 2, 2, 3, 3, running, n);
    e.n  = running ? n : -1;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input int cyc, input logic [26:0] act, input logic [26:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s n=%0d got x=%0d y=%0d von=%b ls=%b fs=%b hs=%b vs=%b want x=%0d y=%0d von=%b ls=%b fs=%b hs=%b vs=%b",
               name, cyc, act[26:17], act[16:7], act[6], act[5], act[4], act[3], act[2],
               exp[26:17], exp[16:7], exp[6], exp[5], exp[4], exp[3], exp[2]);
    end
  endtask

  always @(negedge clk_0) -> sample_ev;

  initial begin : monitor
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_empty at time %0t", $time);
      end else begin
        e = exp_q.pop_front();
        cmp("dut_default", e.n, {if_d.pixel_x, if_d.pixel_y, if_d.video_on, if_d.line_start,
                                 if_d.frame_start, if_d.hsync, if_d.vsync}, e.d);
        cmp("dut_delay0", e.n, {if_s0.pixel_x, if_s0.pixel_y, if_s0.video_on, if_s0.line_start,
                                if_s0.frame_start, if_s0.hsync, if_s0.vsync}, e.s0);
        cmp("dut_delay3", e.n, {if_s3.pixel_x, if_s3.pixel_y, if_s3.video_on, if_s3.line_start,
                                if_s3.frame_start, if_s3.hsync, if_s3.vsync}, e.s3);
      end
    end
  end

  // One clock: expectation for the state after this edge is queued for the
  // negedge monitor.
  task automatic step();
    @(posedge clk_0);
    #1;
    push_expect();
    if (running) n++;
  endtask

  task automatic release_reset();
    #1;
    rst     = 1'b1;
    running = 1'b1;
    n       = 0;
  endtask

  // Reset dropped between edges; outputs must already be at reset values
  // before the next edge arrives.
  task automatic async_reset();
    @(posedge clk_0);
    #2;
    rst     = 1'b0;
    running = 1'b0;
    #1;
    push_expect();
    -> sample_ev;
    push_expect();
  endtask

  initial begin : stimulus
    int hold;
    int run_len;
    repeat (10) step();
    release_reset();
    repeat (1900) step();
    for (int r = 0; r < 3; r++) begin
      async_reset();
      hold = $urandom_range(1, 5);
      repeat (hold) step();
      release_reset();
      run_len = $urandom_range(1300, 2200);
      repeat (run_len) step();
    end
    @(negedge clk_0);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d entries left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
